// File: rtl/bp_pkg.sv
// Shared types and constants for the branch resolution back end.
package bp_pkg;

  typedef logic [31:0] word_t;

  // One in-flight fetched instruction awaiting resolution.
  typedef struct packed {
    word_t pc;
    word_t instr;
    word_t pred_pc;
  } entry_t;

  localparam int    DEPTH_DEFAULT = 4;
  localparam word_t NOP_WORD      = 32'h0;

  // Fall-through address of a non-transferring instruction.
  function automatic word_t next_seq_pc(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pred_queue.sv
// In-order circular FIFO of fetched instructions with synchronous flush.
// push/pop arrive already qualified by the caller; flush overrides both.
module pred_queue
  import bp_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        push_entry,
  output entry_t        head_entry,
  output logic [CW-1:0] count,
  output logic          full
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  assign head_entry = mem[head];
  assign full       = (count == CW'(DEPTH));

  // Entry storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[tail] <= push_entry;
    end
  end

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves the oldest in-flight instruction against the executed outcome,
// raises a redirect on misprediction, feeds the predictor's update port and
// keeps saturating resolution statistics.
module branch_resolve
  import bp_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int CWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              f_valid,
  input  logic [31:0]       f_pc,
  input  logic [31:0]       f_instr,
  input  logic [31:0]       f_pred_pc,
  output logic              f_ready,
  input  logic              e_valid,
  input  logic              e_taken,
  input  logic [31:0]       e_target,
  output logic              redirect,
  output logic [31:0]       redirect_pc,
  output logic              miss,
  output logic [31:0]       last_pc,
  output logic [31:0]       last_instr,
  output logic [CWIDTH-1:0] n_resolved,
  output logic [CWIDTH-1:0] n_miss,
  output logic              protocol_err
);

  localparam int CW = $clog2(DEPTH + 1);

  entry_t        head_entry;
  entry_t        push_entry;
  logic [CW-1:0] count;
  logic          full;
  logic          q_empty;
  logic          resolve;
  logic          push;
  logic          mis;
  word_t         actual;

  assign f_ready    = (count != CW'(DEPTH));
  assign q_empty    = (count == '0);
  assign resolve    = en && e_valid && !q_empty;
  // A push into a full queue is still taken when the head pops in the same cycle.
  assign push       = en && f_valid && (f_ready || resolve);
  assign actual     = e_taken ? e_target : next_seq_pc(head_entry.pc);
  assign mis        = resolve && (actual != head_entry.pred_pc);
  assign push_entry = '{pc: f_pc, instr: f_instr, pred_pc: f_pred_pc};

  pred_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (resolve),
    .flush      (mis),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .count      (count),
    .full       (full)
  );

  // Registered redirect, predictor feedback, statistics and protocol flag; all hold while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect     <= 1'b0;
      redirect_pc  <= '0;
      miss         <= 1'b0;
      last_pc      <= '0;
      last_instr   <= NOP_WORD;
      n_resolved   <= '0;
      n_miss       <= '0;
      protocol_err <= 1'b0;
    end else if (en) begin
      redirect <= mis;
      miss     <= mis;
      if (mis) redirect_pc <= actual;
      if (resolve) begin
        last_pc    <= head_entry.pc;
        last_instr <= head_entry.instr;
        if (n_resolved != '1) n_resolved <= n_resolved + 1'b1;
        if (mis && (n_miss != '1)) n_miss <= n_miss + 1'b1;
      end else begin
        last_instr <= NOP_WORD;
      end
      if (e_valid && q_empty) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with a scoreboard queue of in-flight entries.
module tb_branch_resolve;
  import bp_pkg::*;

  localparam int DEPTH  = 4;
  localparam int CWIDTH = 4;
  localparam int SAT    = (1 << CWIDTH) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              f_valid;
  logic [31:0]       f_pc;
  logic [31:0]       f_instr;
  logic [31:0]       f_pred_pc;
  logic              f_ready;
  logic              e_valid;
  logic              e_taken;
  logic [31:0]       e_target;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              miss;
  logic [31:0]       last_pc;
  logic [31:0]       last_instr;
  logic [CWIDTH-1:0] n_resolved;
  logic [CWIDTH-1:0] n_miss;
  logic              protocol_err;

  branch_resolve #(.DEPTH(DEPTH), .CWIDTH(CWIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .f_valid      (f_valid),
    .f_pc         (f_pc),
    .f_instr      (f_instr),
    .f_pred_pc    (f_pred_pc),
    .f_ready      (f_ready),
    .e_valid      (e_valid),
    .e_taken      (e_taken),
    .e_target     (e_target),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .miss         (miss),
    .last_pc      (last_pc),
    .last_instr   (last_instr),
    .n_resolved   (n_resolved),
    .n_miss       (n_miss),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  entry_t      sb[$];
  logic        m_redirect;
  logic [31:0] m_redirect_pc;
  logic        m_miss;
  logic [31:0] m_last_pc;
  logic [31:0] m_last_instr;
  int          m_nres;
  int          m_nmiss;
  logic        m_perr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".f_ready"},      32'(f_ready),      32'(sb.size() != DEPTH));
    check({tag, ".redirect"},     32'(redirect),     32'(m_redirect));
    check({tag, ".redirect_pc"},  redirect_pc,       m_redirect_pc);
    check({tag, ".miss"},         32'(miss),         32'(m_miss));
    check({tag, ".last_pc"},      last_pc,           m_last_pc);
    check({tag, ".last_instr"},   last_instr,        m_last_instr);
    check({tag, ".n_resolved"},   32'(n_resolved),   32'(m_nres));
    check({tag, ".n_miss"},       32'(n_miss),       32'(m_nmiss));
    check({tag, ".protocol_err"}, 32'(protocol_err), 32'(m_perr));
  endtask

  task automatic model_reset();
    sb.delete();
    m_redirect = 0; m_redirect_pc = 0; m_miss = 0; m_last_pc = 0;
    m_last_instr = 0; m_nres = 0; m_nmiss = 0; m_perr = 0;
  endtask

  // Expected effect of one clock edge, computed from pre-edge model state.
  task automatic model_step(input logic e, input logic fv, input logic [31:0] pc,
                            input logic [31:0] ins, input logic [31:0] pred,
                            input logic ev, input logic tk, input logic [31:0] tgt);
    entry_t      h;
    logic        ready;
    logic        res;
    logic        mp;
    logic [31:0] act;
    if (!e) return;
    ready = (sb.size() != DEPTH);
    res   = ev && (sb.size() != 0);
    mp    = 0;
    act   = 0;
    if (ev && sb.size() == 0) m_perr = 1;
    if (res) begin
      h   = sb.pop_front();
      act = tk ? tgt : h.pc + 32'd4;
      mp  = (act != h.pred_pc);
      m_last_pc    = h.pc;
      m_last_instr = h.instr;
      if (m_nres < SAT) m_nres++;
      if (mp && m_nmiss < SAT) m_nmiss++;
    end else begin
      m_last_instr = 0;
    end
    m_miss     = mp;
    m_redirect = mp;
    if (mp) begin
      m_redirect_pc = act;
      sb.delete();
    end else if (fv && (ready || res)) begin
      sb.push_back('{pc: pc, instr: ins, pred_pc: pred});
    end
  endtask

  task automatic step(input string tag, input logic e, input logic fv, input logic [31:0] pc,
                      input logic [31:0] ins, input logic [31:0] pred,
                      input logic ev, input logic tk, input logic [31:0] tgt);
    en = e; f_valid = fv; f_pc = pc; f_instr = ins; f_pred_pc = pred;
    e_valid = ev; e_taken = tk; e_target = tgt;
    model_step(e, fv, pc, ins, pred, ev, tk, tgt);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic push_only(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] pred);
    step(tag, 1, 1, pc, ins, pred, 0, 0, 0);
  endtask

  task automatic resolve_only(input string tag, input logic tk, input logic [31:0] tgt);
    step(tag, 1, 0, 0, 0, 0, 1, tk, tgt);
  endtask

  task automatic idle(input string tag);
    step(tag, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; en = 0; f_valid = 0; f_pc = 0; f_instr = 0; f_pred_pc = 0;
    e_valid = 0; e_taken = 0; e_target = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 0;

    // Sequential instruction resolved correctly.
    push_only("t1_push", 32'h100, 32'h0000_0013, 32'h104);
    resolve_only("t1_res", 0, 0);
    idle("t1_idle");

    // Taken branch predicted not-taken flushes younger entries.
    push_only("t2_beq", 32'h200, 32'h00a5_0463, 32'h204);
    push_only("t2_p1",  32'h204, 32'h0000_0013, 32'h208);
    push_only("t2_p2",  32'h208, 32'h0000_0013, 32'h20c);
    resolve_only("t2_mis", 1, 32'h300);
    idle("t2_after");
    push_only("t2_fresh", 32'h300, 32'h0000_0093, 32'h304);
    resolve_only("t2_fresh_res", 0, 0);

    // Predicted-taken jump resolved correctly.
    push_only("t3_push", 32'h3f0, 32'h0100_006f, 32'h400);
    resolve_only("t3_res", 1, 32'h400);

    // Fill, overflow drop, push+pop while full, then drain in order.
    for (int i = 0; i < DEPTH; i++)
      push_only("t4_fill", 32'h500 + 32'(i * 4), 32'hA000 + 32'(i), 32'h504 + 32'(i * 4));
    push_only("t4_drop", 32'h5f0, 32'hDEAD, 32'h5f4);
    step("t4_pushpop", 1, 1, 32'h510, 32'hA004, 32'h514, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) resolve_only("t4_drain", 0, 0);
    idle("t4_empty");

    // Mispredict discards the same-cycle push; then resolve on an empty queue.
    push_only("t5_push", 32'h600, 32'h1111, 32'h604);
    step("t5_mis_push", 1, 1, 32'h700, 32'h2222, 32'h704, 1, 1, 32'h700);
    resolve_only("t5_empty_res", 0, 0);
    resolve_only("t5_empty_res2", 1, 32'h123);
    idle("t5_sticky");

    // Stall: enable low with both valids asserted.
    push_only("t6_push", 32'h800, 32'h3333, 32'h804);
    for (int i = 0; i < 3; i++) step("t6_stall", 0, 1, 32'h900, 32'h4444, 32'h904, 1, 1, 32'h999);
    resolve_only("t6_res", 0, 0);
    idle("t6_idle");

    // Repeated mispredicts saturate both counters.
    for (int i = 0; i < 16; i++) begin
      push_only("t7_push", 32'hA00 + 32'(i * 16), 32'h5000 + 32'(i), 32'h0);
      resolve_only("t7_mis", 0, 0);
    end
    idle("t7_sat");

    // Reset asserted while a redirect is showing.
    push_only("t8_push", 32'hB00, 32'h6666, 32'hB04);
    resolve_only("t8_mis", 1, 32'hC00);
    reset = 1;
    model_reset();
    #1;
    check_all("t8_reset");
    #2;
    reset = 0;
    idle("t8_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Back-end partner of the front-end branch predictor.
- Records every fetched instruction's PC, instruction word and predicted next PC in an in-order queue.
- At execute, resolves the head entry against the actual outcome and raises a pipeline redirect on mismatch.
- Drives the predictor's update interface (miss, last_pc, last_instr) and keeps resolution/miss statistics.

Parameters:
DEPTH, 4, in-flight queue entries (power of two, >= 2)
CWIDTH, 32, width of the statistics counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  global enable; 0 = stall, all state and outputs hold
f_valid  input  1  fetch pushes an entry this cycle
f_pc  input  32  PC of the fetched instruction
f_instr  input  32  fetched instruction word
f_pred_pc  input  32  predictor's pred_pc for that instruction
f_ready  output  1  queue can accept a push (not full)
e_valid  input  1  execute resolves the head entry this cycle
e_taken  input  1  actual control transfer taken (1 for all jumps)
e_target  input  32  actual transfer target (ignored when e_taken=0)
redirect  output  1  one-cycle pulse: fetch must restart at redirect_pc
redirect_pc  output  32  corrected fetch address
miss  output  1  feedback to predictor: last resolution mispredicted
last_pc  output  32  feedback: PC of last resolved instruction
last_instr  output  32  feedback: word of last resolved instruction, 0 when none
n_resolved  output  CWIDTH  saturating count of resolutions
n_miss  output  CWIDTH  saturating count of mispredictions
protocol_err  output  1  sticky: e_valid seen with empty queue

Behaviour:
- Reset (async): head, tail and count = 0; all outputs 0 except f_ready = 1.
- en=0: nothing changes; f_valid and e_valid are ignored.
- f_ready = (count != DEPTH), combinational from count only. A push when full is dropped; it is the caller's error.
- Push (en & f_valid & f_ready): write {f_pc, f_instr, f_pred_pc} at tail; tail wraps modulo DEPTH; count += 1.
- Resolve (en & e_valid & count != 0): read head entry H.
  - actual = e_taken ? e_target : H.pc + 32'd4 (modulo 2^32).
  - mis = (actual != H.pred_pc).
  - Pop the head (head wraps modulo DEPTH).
- Simultaneous push and pop without mis: count unchanged; this is legal when full.
- Misprediction flush:
  - count, head and tail are all set to 0.
  - Any same-cycle push is discarded.
  - The next cycle's registered outputs are redirect = 1 and redirect_pc = actual.
- Feedback outputs are registered, visible one cycle after the resolving edge, and held for one cycle:
  - miss = mis, last_pc = H.pc, last_instr = H.instr.
  - On every other enabled cycle: miss = 0, last_instr = 0 (a NOP, so the predictor performs no update); last_pc holds its value.
  - redirect is 0 on every enabled cycle without mis; redirect_pc holds its value.
- Counters: n_resolved += 1 per resolve; n_miss += 1 per mis. Both saturate at all-ones; no wrap.
- Empty-queue resolve: e_valid with count=0 sets protocol_err (sticky until reset). No pop, no redirect; feedback outputs are as on an idle cycle.
- Reset mid-flush: reset dominates and clears a pending redirect.

Decomposition:
- Shared package bp_pkg: Word typedef (logic [31:0]), entry struct {pc, instr, pred_pc}, DEPTH default, NOP_WORD constant (32'h0).
- Sub-module pred_queue: circular FIFO with push, pop and synchronous flush; exposes head entry, count and full.
- branch_resolve contains the compare, redirect, feedback and counter logic.

Test Plan:
- Reset, then push pc=0x100 with pred 0x104 (non-branch); resolve e_taken=0 -> next cycle miss=0, last_pc=0x100, last_instr=f_instr, redirect=0, n_resolved=1, n_miss=0.
- Push beq at 0x200 with pred 0x204, then 0x204 and 0x208; resolve head e_taken=1, e_target=0x300 -> redirect=1 and redirect_pc=0x300 for exactly one cycle; miss=1; count=0; n_miss=1.
- Fill DEPTH=4 entries -> f_ready=0. Push again -> dropped. Same-cycle correct resolve plus push -> count stays 4 and the FIFO order is preserved.
- Resolve with predicted-taken correct (pred 0x400, e_taken=1, target 0x400) -> miss=0, redirect=0.
- e_valid with empty queue -> protocol_err=1 and stays 1; no counter change. Assert reset while a redirect is pending -> all outputs 0 immediately.
- Hold en=0 for 3 cycles with f_valid=e_valid=1 -> no state change. Force n_miss to all-ones via repeated misses (CWIDTH=4) -> saturates at 15.
